// File: rtl/operand_fetch.sv
// Operand-fetch stage feeding the 16-bit ALU: 8x16 register file, one read
// port, one write port, A/B operand capture and a valid/ready handoff.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (accepted only in IDLE)
//   rn, rm               A / B operand register indices
//   shift                op on Rm: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   bsel_imm, sximm5     select sign-extended immediate as B
//   asel_zero            force A to zero
//   wr_en/addr/data      register-file write port (active in every state)
//   ain, bin             operand pair to the ALU
//   op_valid/op_ready    operand handshake toward the ALU side
module operand_fetch #(
    parameter int DW    = 16,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] rn,
    input  logic [AW-1:0] rm,
    input  logic [1:0]    shift,
    input  logic          bsel_imm,
    input  logic [DW-1:0] sximm5,
    input  logic          asel_zero,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] ain,
    output logic [DW-1:0] bin,
    output logic          op_valid,
    input  logic          op_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_A  = 2'd1,
        RD_B  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [DW-1:0] r_rf [NREGS];

    logic [AW-1:0] r_rn;
    logic [AW-1:0] r_rm;
    logic [1:0]    r_shift;
    logic          r_bsel;
    logic [DW-1:0] r_imm;
    logic          r_azero;

    logic [DW-1:0] r_ain;
    logic [DW-1:0] r_bin;

    logic [AW-1:0] w_rd_idx;
    logic [DW-1:0] w_rd_data;
    logic [DW-1:0] w_shifted;

    // Single read port: Rn is read in RD_A, Rm in RD_B.
    assign w_rd_idx = (r_state == RD_A) ? r_rn : r_rm;

    // A same-edge write to the index being read wins over the stored value.
    assign w_rd_data = (wr_en && (wr_addr == w_rd_idx))
                     ? wr_data : r_rf[w_rd_idx];

    always_comb begin
        w_shifted = w_rd_data;
        case (r_shift)
            2'b01:   w_shifted = {w_rd_data[DW-2:0], 1'b0};
            2'b10:   w_shifted = {1'b0, w_rd_data[DW-1:1]};
            2'b11:   w_shifted = {w_rd_data[DW-1], w_rd_data[DW-1:1]};
            default: w_shifted = w_rd_data;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = RD_A;
            RD_A:    w_next = RD_B;
            RD_B:    w_next = ISSUE;
            ISSUE:   if (op_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Register file; a write coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wr_en) begin
            r_rf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rn    <= '0;
            r_rm    <= '0;
            r_shift <= '0;
            r_bsel  <= 1'b0;
            r_imm   <= '0;
            r_azero <= 1'b0;
            r_ain   <= '0;
            r_bin   <= '0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_rn    <= rn;
                r_rm    <= rm;
                r_shift <= shift;
                r_bsel  <= bsel_imm;
                r_imm   <= sximm5;
                r_azero <= asel_zero;
            end
            if (r_state == RD_A) begin
                r_ain <= r_azero ? '0 : w_rd_data;
            end
            if (r_state == RD_B) begin
                r_bin <= r_bsel ? r_imm : w_shifted;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign op_valid  = (r_state == ISSUE);
    assign ain       = r_ain;
    assign bin       = r_bin;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic        bsel_imm;
    logic [15:0] sximm5;
    logic        asel_zero;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] ain;
    logic [15:0] bin;
    logic        op_valid;
    logic        op_ready;

    int total = 0;
    int bad   = 0;

    operand_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rn        (rn),
        .rm        (rm),
        .shift     (shift),
        .bsel_imm  (bsel_imm),
        .sximm5    (sximm5),
        .asel_zero (asel_zero),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ain       (ain),
        .bin       (bin),
        .op_valid  (op_valid),
        .op_ready  (op_ready)
    );

    always #5 clk = ~clk;

    // Reference model: register contents, the pending request, and how many
    // edges have passed since it was accepted (0 = no request in flight).
    logic [15:0] m_mem [8];
    int          m_age;
    logic [2:0]  q_rn, q_rm;
    logic [1:0]  q_shift;
    logic        q_bsel, q_az;
    logic [15:0] q_imm;
    logic [15:0] m_ain, m_bin;

    function automatic logic [15:0] shop(logic [15:0] x, logic [1:0] s);
        logic [15:0] r;
        case (s)
            2'b01:   r = x << 1;
            2'b10:   r = x >> 1;
            2'b11:   r = 16'($signed(x) >>> 1);
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] rdval(logic [2:0] idx);
        if (wr_en && wr_addr == idx) return wr_data;
        return m_mem[idx];
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
            m_age = 0;
            m_ain = 16'h0;
            m_bin = 16'h0;
            return;
        end
        if (m_age == 0) begin
            if (req_valid) begin
                q_rn = rn; q_rm = rm; q_shift = shift;
                q_bsel = bsel_imm; q_imm = sximm5; q_az = asel_zero;
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_ain = q_az ? 16'h0 : rdval(q_rn);
            m_age = 2;
        end else if (m_age == 2) begin
            m_bin = q_bsel ? q_imm : shop(rdval(q_rm), q_shift);
            m_age = 3;
        end else if (op_ready) begin
            m_age = 0;
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    // One clock: model advances on the rising edge, DUT is compared on
    // the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ain", ain, m_ain);
        chk("bin", bin, m_bin);
        chk("op_valid", 16'(op_valid), 16'(m_age == 3));
        chk("req_ready", 16'(req_ready), 16'(m_age == 0));
    endtask

    task automatic wr(logic [2:0] a, logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic scramble_fields();
        rn = 3'($urandom); rm = 3'($urandom); shift = 2'($urandom);
        bsel_imm = 1'($urandom); sximm5 = 16'($urandom);
        asel_zero = 1'($urandom);
    endtask

    // Accept a request and advance to the ISSUE cycle.
    task automatic req(logic [2:0] a, logic [2:0] b, logic [1:0] s,
                       logic bs, logic [15:0] im, logic az);
        req_valid = 1'b1; rn = a; rm = b; shift = s;
        bsel_imm = bs; sximm5 = im; asel_zero = az;
        step();
        req_valid = 1'b0;
        scramble_fields();
        step();
        step();
        chk("issue_valid", 16'(op_valid), 16'h1);
    endtask

    logic [15:0] hold_a, hold_b;

    initial begin
        reset = 1'b1; req_valid = 1'b0; op_ready = 1'b1;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
        rn = 3'd0; rm = 3'd0; shift = 2'b00;
        bsel_imm = 1'b0; sximm5 = 16'h0; asel_zero = 1'b0;
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
        m_age = 0; m_ain = 16'h0; m_bin = 16'h0;
        step();
        step();
        chk("rst_ain", ain, 16'h0);
        chk("rst_bin", bin, 16'h0);
        chk("rst_valid", 16'(op_valid), 16'h0);
        chk("rst_ready", 16'(req_ready), 16'h1);
        reset = 1'b0;

        wr(3'd0, 16'h0005);
        wr(3'd1, 16'h0003);
        req(3'd0, 3'd1, 2'b00, 1'b0, 16'h0, 1'b0);
        chk("basic_ain", ain, 16'h0005);
        chk("basic_bin", bin, 16'h0003);
        step();
        chk("basic_drop", 16'(op_valid), 16'h0);

        wr(3'd2, 16'h8002);
        req(3'd0, 3'd2, 2'b01, 1'b0, 16'h0, 1'b0);
        chk("lsl1", bin, 16'h0004);
        step();
        req(3'd0, 3'd2, 2'b10, 1'b0, 16'h0, 1'b0);
        chk("lsr1", bin, 16'h4001);
        step();
        req(3'd0, 3'd2, 2'b11, 1'b0, 16'h0, 1'b0);
        chk("asr1", bin, 16'hC001);
        step();

        req(3'd1, 3'd2, 2'b01, 1'b1, 16'hFFF0, 1'b1);
        chk("imm_ain", ain, 16'h0000);
        chk("imm_bin", bin, 16'hFFF0);
        step();

        op_ready = 1'b0;
        req(3'd1, 3'd0, 2'b00, 1'b0, 16'h0, 1'b0);
        hold_a = ain; hold_b = bin;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 16'(op_valid), 16'h1);
            chk("stall_ready", 16'(req_ready), 16'h0);
            chk("stall_ain", ain, hold_a);
            chk("stall_bin", bin, hold_b);
        end
        op_ready = 1'b1;
        step();
        chk("release_valid", 16'(op_valid), 16'h0);
        chk("release_ready", 16'(req_ready), 16'h1);

        wr(3'd3, 16'h1111);
        req_valid = 1'b1; rn = 3'd3; rm = 3'd0; shift = 2'b00;
        bsel_imm = 1'b0; asel_zero = 1'b0;
        step();
        req_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h2222;
        step();
        wr_en = 1'b0;
        step();
        chk("bypass_ain", ain, 16'h2222);
        step();

        req_valid = 1'b1; rn = 3'd3; rm = 3'd2; shift = 2'b00;
        bsel_imm = 1'b0; asel_zero = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_valid", 16'(op_valid), 16'h0);
        chk("abort_ready", 16'(req_ready), 16'h1);
        chk("abort_ain", ain, 16'h0);
        chk("abort_bin", bin, 16'h0);
        step();
        step();
        req(3'd3, 3'd2, 2'b00, 1'b0, 16'h0, 1'b0);
        chk("cleared_a", ain, 16'h0);
        chk("cleared_b", bin, 16'h0);
        step();

        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(99) < 2);
            req_valid = ($urandom_range(99) < 60);
            op_ready  = ($urandom_range(99) < 60);
            wr_en     = ($urandom_range(99) < 35);
            wr_addr   = 3'($urandom);
            wr_data   = 16'($urandom);
            scramble_fields();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
